// File: rtl/cluster_ctrl.sv
// Sequencer for a tree-structured PE array: streams points down the tree, updates, sorts and
// repeats until the array reports stability. Define CLUSTER_CTRL_ITER_LIMIT_EN to cap iterations.
module cluster_ctrl #(
    parameter int unsigned MAX_N      = 1000,
    parameter int unsigned MAX_DEPTH  = 16,
    parameter int unsigned DIM        = 3,
    parameter int unsigned DATA_RANGE = 255,
    parameter int unsigned MAX_ITER   = 64,
    localparam int unsigned CNT_W     = $clog2(MAX_N + 1),
    localparam int unsigned DEP_W     = $clog2(MAX_DEPTH + 1),
    localparam int unsigned PT_W      = DIM * $clog2(DATA_RANGE),
    localparam int unsigned IT_W      = $clog2(MAX_ITER + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // Run control
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_points_i,
    input  logic [DEP_W-1:0] tree_depth_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [IT_W-1:0]  iter_count_o,
    // Point source
    input  logic             pt_valid_i,
    input  logic [PT_W-1:0]  pt_data_i,
    output logic             pt_ready_o,
    // PE array controls
    output logic             pe_en_o,
    output logic             pe_init_o,
    output logic             pe_start_iter_o,
    output logic             pe_receive_point_o,
    output logic             pe_next_level_o,
    output logic             pe_inc_o,
    output logic             pe_update_o,
    output logic             pe_sorting_o,
    output logic [PT_W-1:0]  pe_point_o,
    // PE array status
    input  logic             stable_i
);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StIterStart,
        StFetch,
        StDescend,
        StInc,
        StUpdate,
        StSort,
        StCheck,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] n_q, n_d;
    logic [DEP_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic [DEP_W-1:0] lvl_q, lvl_d;
    logic             got_q, got_d;
    logic [PT_W-1:0]  pt_q, pt_d;
    logic [IT_W-1:0]  iter_q, iter_d;

`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
    logic             timeout_q, timeout_d;
`endif

    logic [DEP_W-1:0] depth_clamp;
    logic [CNT_W-1:0] pt_cnt_inc;
    logic [IT_W-1:0]  iter_inc;
    logic             descend_last;

    assign depth_clamp = (tree_depth_i > DEP_W'(MAX_DEPTH)) ? DEP_W'(MAX_DEPTH) : tree_depth_i;
    assign pt_cnt_inc  = pt_cnt_q + CNT_W'(1);
    assign iter_inc    = (iter_q == '1) ? iter_q : iter_q + IT_W'(1);
    // A zero-depth tree still spends one (idle) cycle in DESCEND.
    assign descend_last = (depth_q == '0) || (lvl_q == depth_q - DEP_W'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_q       <= '0;
            depth_q   <= '0;
            pt_cnt_q  <= '0;
            lvl_q     <= '0;
            got_q     <= 1'b0;
            pt_q      <= '0;
            iter_q    <= '0;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            n_q       <= n_d;
            depth_q   <= depth_d;
            pt_cnt_q  <= pt_cnt_d;
            lvl_q     <= lvl_d;
            got_q     <= got_d;
            pt_q      <= pt_d;
            iter_q    <= iter_d;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        depth_d  = depth_q;
        pt_cnt_d = pt_cnt_q;
        lvl_d    = lvl_q;
        got_d    = got_q;
        pt_d     = pt_q;
        iter_d   = iter_q;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
        timeout_d = timeout_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
                    timeout_d = 1'b0;
`endif
                    if (n_points_i != '0) begin
                        n_d     = n_points_i;
                        depth_d = depth_clamp;
                        iter_d  = '0;
                        state_d = StInit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StInit: begin
                state_d = StIterStart;
            end
            StIterStart: begin
                pt_cnt_d = '0;
                state_d  = StFetch;
            end
            StFetch: begin
                // got_q marks the receive cycle that follows an accepted point.
                if (got_q) begin
                    got_d   = 1'b0;
                    lvl_d   = '0;
                    state_d = StDescend;
                end else if (pt_valid_i) begin
                    pt_d  = pt_data_i;
                    got_d = 1'b1;
                end
            end
            StDescend: begin
                if (descend_last) begin
                    lvl_d   = '0;
                    state_d = StInc;
                end else begin
                    lvl_d = lvl_q + DEP_W'(1);
                end
            end
            StInc: begin
                pt_cnt_d = pt_cnt_inc;
                state_d  = (pt_cnt_inc == n_q) ? StUpdate : StFetch;
            end
            StUpdate: begin
                lvl_d   = '0;
                state_d = StSort;
            end
            StSort: begin
                // Sorting runs depth+1 cycles: lvl_q counts 0..depth.
                if (lvl_q == depth_q) begin
                    lvl_d   = '0;
                    state_d = StCheck;
                end else begin
                    lvl_d = lvl_q + DEP_W'(1);
                end
            end
            StCheck: begin
                if (stable_i) begin
                    state_d = StDone;
                end else begin
                    iter_d = iter_inc;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
                    if (iter_inc == IT_W'(MAX_ITER)) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StIterStart;
                    end
`else
                    state_d = StIterStart;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy_o             = (state_q != StIdle);
        pe_en_o            = (state_q != StIdle);
        done_o             = 1'b0;
        pt_ready_o         = 1'b0;
        pe_init_o          = 1'b0;
        pe_start_iter_o    = 1'b0;
        pe_receive_point_o = 1'b0;
        pe_next_level_o    = 1'b0;
        pe_inc_o           = 1'b0;
        pe_update_o        = 1'b0;
        pe_sorting_o       = 1'b0;

        unique case (state_q)
            StInit:      pe_init_o       = 1'b1;
            StIterStart: pe_start_iter_o = 1'b1;
            StFetch: begin
                pt_ready_o         = !got_q;
                pe_receive_point_o = got_q;
            end
            StDescend:   pe_next_level_o = (depth_q != '0);
            StInc:       pe_inc_o        = 1'b1;
            StUpdate:    pe_update_o     = 1'b1;
            StSort:      pe_sorting_o    = 1'b1;
            StDone:      done_o          = 1'b1;
            default: ;
        endcase
    end

    assign pe_point_o   = pt_q;
    assign iter_count_o = iter_q;

`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
